regbank_64: RTL and testbench

REGBANK_64 -- requirements
Module: regbank_64

---
 rtl/regbank_64_pkg.sv | 19 +
 rtl/regbank_64_register_32.sv | 22 ++
 rtl/regbank_64.sv | 62 ++++++
 tb/tb_regbank_64.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_64_pkg.sv
// Shared constants and helpers for the 64-entry register bank.
// Entry 0 is hardwired to zero, so address 0 never commits a write or a reserve.
package regbank_64_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 64;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned SLICE_W  = DATA_W;
  localparam int unsigned COUNT_W  = 16;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [COUNT_W-1:0] count_t;

  // A request commits only when it targets a real (non-zero) entry.
  function automatic logic is_commit(input logic en, input addr_t addr);
    return en && (addr != '0);
  endfunction

endpackage

// File: rtl/regbank_64_register_32.sv
// One register-bank entry: a data register with load enable and async active-high reset.
module register_32
  import regbank_64_pkg::*;
#(
  parameter int unsigned WIDTH = SLICE_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regbank_64.sv
// 64-entry register bank with a zero entry, a busy scoreboard and a committed-write counter.
// All outputs come straight from flops; there is no write-to-read bypass.
module regbank_64
  import regbank_64_pkg::*;
#(
  parameter int unsigned DATA_W   = regbank_64_pkg::DATA_W,
  parameter int unsigned NUM_REGS = regbank_64_pkg::NUM_REGS
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                wr_en,
  input  logic [regbank_64_pkg::ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]                   wr_data,
  input  logic                                rsv_en,
  input  logic [regbank_64_pkg::ADDR_W-1:0]   rsv_addr,
  output logic [DATA_W*NUM_REGS-1:0]          q_all,
  output logic [NUM_REGS-1:0]                 busy,
  output logic [regbank_64_pkg::COUNT_W-1:0]  wr_count
);

  logic                  wr_commit;
  logic                  rsv_commit;
  logic [NUM_REGS-1:1]   wr_sel;

  always_comb begin
    wr_commit  = is_commit(wr_en, wr_addr);
    rsv_commit = is_commit(rsv_en, rsv_addr);
  end

  assign q_all[DATA_W-1:0] = '0;

  for (genvar k = 1; k < NUM_REGS; k++) begin : g_entry
    assign wr_sel[k] = wr_commit && (wr_addr == addr_t'(k));

    register_32 #(
      .WIDTH(DATA_W)
    ) u_reg (
      .clock (clock),
      .reset (reset),
      .en    (wr_sel[k]),
      .d     (wr_data),
      .q     (q_all[k*DATA_W +: DATA_W])
    );
  end

  // The reserve assignment follows the write-clear so a same-entry reserve wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      wr_count <= '0;
    end else begin
      if (wr_commit) begin
        busy[wr_addr] <= 1'b0;
        wr_count      <= wr_count + count_t'(1);
      end
      if (rsv_commit) begin
        busy[rsv_addr] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regbank_64.sv
// Self-checking bench for regbank_64: a behavioural model pushes expected snapshots
// into a scoreboard as stimulus is driven; each test pops and compares after the edge.
module tb_regbank_64;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 64;
  localparam int unsigned QW = W * N;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [5:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic          rsv_en;
  logic [5:0]    rsv_addr;
  logic [QW-1:0] q_all;
  logic [N-1:0]  busy;
  logic [15:0]   wr_count;

  typedef struct {
    logic [QW-1:0] q;
    logic [N-1:0]  busy;
    logic [15:0]   cnt;
  } snap_t;

  snap_t        sb[$];
  logic [W-1:0] m_mem [N];
  logic [N-1:0] m_busy;
  logic [15:0]  m_cnt;
  int unsigned  checks   = 0;
  int unsigned  failures = 0;

  regbank_64 #(
    .DATA_W   (32),
    .NUM_REGS (64)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .q_all    (q_all),
    .busy     (busy),
    .wr_count (wr_count)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [QW-1:0] pack_mem();
    logic [QW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = m_mem[k];
    return r;
  endfunction

  function automatic int first_diff(input logic [QW-1:0] a, input logic [QW-1:0] b);
    for (int k = 0; k < N; k++) if (a[k*W +: W] !== b[k*W +: W]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_mem[k] = '0;
    m_busy = '0;
    m_cnt  = '0;
  endtask

  // Drive one cycle's requests, advance the model and push the expected post-edge state.
  task automatic drive(input logic we, input logic [5:0] wa, input logic [W-1:0] wd,
                       input logic re, input logic [5:0] ra);
    snap_t s;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra;
    if (we && wa != 6'd0) begin
      m_mem[wa]  = wd;
      m_busy[wa] = 1'b0;
      m_cnt      = m_cnt + 16'd1;
    end
    if (re && ra != 6'd0) m_busy[ra] = 1'b1;
    s.q = pack_mem(); s.busy = m_busy; s.cnt = m_cnt;
    sb.push_back(s);
  endtask

  task automatic edge_wait();
    @(posedge clock);
    #1;
    wr_en = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic step(input logic we, input logic [5:0] wa, input logic [W-1:0] wd,
                      input logic re, input logic [5:0] ra);
    drive(we, wa, wd, re, ra);
    edge_wait();
  endtask

  task automatic test_reset();
    snap_t s;
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
    #2;
    checks++;
    if (q_all !== '0) begin
      failures++;
      $display("FAIL reset_q_all slice=%0d got=%h want=0", first_diff(q_all, '0),
               q_all[first_diff(q_all, '0)*W +: W]);
    end
    checks++;
    if (busy !== '0) begin failures++; $display("FAIL reset_busy got=%h want=0", busy); end
    checks++;
    if (wr_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%h want=0", wr_count); end
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    sb.delete();
  endtask

  task automatic test_write_basic();
    snap_t s;
    drive(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0);
    #2;
    checks++;
    if (q_all[5*W +: W] !== 32'h0 || wr_count !== 16'h0) begin
      failures++;
      $display("FAIL write5_latency got=%h/%h want=0/0", q_all[5*W +: W], wr_count);
    end
    edge_wait();
    s = sb.pop_front();
    checks++;
    if (q_all !== s.q) begin
      failures++;
      $display("FAIL write5_q_all slice=%0d got=%h want=%h", first_diff(q_all, s.q),
               q_all[first_diff(q_all, s.q)*W +: W], s.q[first_diff(q_all, s.q)*W +: W]);
    end
    checks++;
    if (q_all[5*W +: W] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL write5_slice got=%h want=deadbeef", q_all[5*W +: W]);
    end
    checks++;
    if (wr_count !== 16'd1 || wr_count !== s.cnt) begin
      failures++; $display("FAIL write5_count got=%h want=%h", wr_count, s.cnt);
    end
    checks++;
    if (busy !== '0) begin failures++; $display("FAIL write5_busy got=%h want=0", busy); end
  endtask

  task automatic test_write_zero();
    snap_t s;
    step(1'b1, 6'd0, 32'h12345678, 1'b0, 6'd0);
    s = sb.pop_front();
    checks++;
    if (q_all[W-1:0] !== 32'h0) begin
      failures++; $display("FAIL write0_slice got=%h want=0", q_all[W-1:0]);
    end
    checks++;
    if (wr_count !== 16'd1 || wr_count !== s.cnt) begin
      failures++; $display("FAIL write0_count got=%h want=1", wr_count);
    end
    checks++;
    if (q_all !== s.q) begin
      failures++; $display("FAIL write0_q_all slice=%0d", first_diff(q_all, s.q));
    end
  endtask

  task automatic test_reserve();
    snap_t s;
    step(1'b0, 6'd0, '0, 1'b1, 6'd9);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step(1'b0, 6'd0, '0, 1'b0, 6'd0);
      s = sb.pop_front();
      checks++;
      if (busy[9] !== 1'b1 || busy !== s.busy) begin
        failures++; $display("FAIL rsv9_hold cyc=%0d got=%h want=%h", i, busy, s.busy);
      end
    end
    step(1'b1, 6'd9, 32'hA5A5A5A5, 1'b0, 6'd0);
    s = sb.pop_front();
    checks++;
    if (busy[9] !== 1'b0 || busy !== s.busy) begin
      failures++; $display("FAIL rsv9_clear got=%h want=%h", busy, s.busy);
    end
    checks++;
    if (q_all[9*W +: W] !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL rsv9_slice got=%h want=a5a5a5a5", q_all[9*W +: W]);
    end
    checks++;
    if (q_all !== s.q) begin
      failures++; $display("FAIL rsv9_q_all slice=%0d", first_diff(q_all, s.q));
    end
  endtask

  task automatic test_same_cycle();
    snap_t s;
    step(1'b1, 6'd12, 32'h1, 1'b1, 6'd12);
    s = sb.pop_front();
    checks++;
    if (q_all[12*W +: W] !== 32'h1 || busy[12] !== 1'b1) begin
      failures++;
      $display("FAIL same12 got=%h/%b want=1/1", q_all[12*W +: W], busy[12]);
    end
    step(1'b1, 6'd3, 32'h0BADF00D, 1'b1, 6'd4);
    s = sb.pop_front();
    checks++;
    if (busy[3] !== 1'b0 || busy[4] !== 1'b1 || busy !== s.busy) begin
      failures++; $display("FAIL diff3_4 got=%h want=%h", busy, s.busy);
    end
    step(1'b0, 6'd0, '0, 1'b1, 6'd4);
    s = sb.pop_front();
    checks++;
    if (busy[4] !== 1'b1 || busy !== s.busy) begin
      failures++; $display("FAIL rerserve4 got=%h want=%h", busy, s.busy);
    end
    step(1'b1, 6'd12, 32'h22, 1'b1, 6'd0);
    s = sb.pop_front();
    checks++;
    if (busy[12] !== 1'b0 || busy[0] !== 1'b0 || busy !== s.busy) begin
      failures++; $display("FAIL clear12_rsv0 got=%h want=%h", busy, s.busy);
    end
    checks++;
    if (q_all !== s.q || wr_count !== s.cnt) begin
      failures++;
      $display("FAIL same_state slice=%0d cnt got=%h want=%h", first_diff(q_all, s.q), wr_count, s.cnt);
    end
  endtask

  task automatic test_fill_reset();
    snap_t s;
    for (int k = 1; k < N; k++) begin
      step(1'b1, 6'(k), {8'(k), 8'hC3, 8'(k * 3), 8'h5A}, 1'b0, 6'd0);
      s = sb.pop_front();
      checks++;
      if (q_all !== s.q) begin
        failures++;
        $display("FAIL fill k=%0d slice=%0d got=%h want=%h", k, first_diff(q_all, s.q),
                 q_all[first_diff(q_all, s.q)*W +: W], s.q[first_diff(q_all, s.q)*W +: W]);
      end
    end
    step(1'b0, 6'd0, '0, 1'b1, 6'd20);
    s = sb.pop_front();
    checks++;
    if (busy !== s.busy || wr_count !== s.cnt) begin
      failures++; $display("FAIL fill_state busy=%h want=%h cnt=%h want=%h", busy, s.busy, wr_count, s.cnt);
    end
    #2;
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 6'd7; wr_data = 32'hFFFF0000;
    rsv_en = 1'b1; rsv_addr = 6'd7;
    #1;
    checks++;
    if (q_all !== '0 || busy !== '0 || wr_count !== 16'h0) begin
      failures++;
      $display("FAIL async_reset slice=%0d busy=%h cnt=%h want=0", first_diff(q_all, '0), busy, wr_count);
    end
    @(posedge clock); #1;
    checks++;
    if (q_all !== '0 || busy !== '0 || wr_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_discard slice=%0d busy=%h cnt=%h want=0", first_diff(q_all, '0), busy, wr_count);
    end
    reset = 1'b0;
    model_reset();
    sb.delete();
    step(1'b1, 6'd7, 32'h13579BDF, 1'b1, 6'd8);
    s = sb.pop_front();
    checks++;
    if (q_all[7*W +: W] !== 32'h13579BDF || busy !== 64'h100 || wr_count !== 16'd1) begin
      failures++;
      $display("FAIL resume got=%h/%h/%h want=13579bdf/100/1", q_all[7*W +: W], busy, wr_count);
    end
    checks++;
    if (q_all !== s.q) begin
      failures++; $display("FAIL resume_q_all slice=%0d", first_diff(q_all, s.q));
    end
  endtask

  task automatic test_wrap();
    snap_t       s;
    int unsigned bad = 0;
    reset = 1'b1;
    #2;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    sb.delete();
    for (int i = 0; i < 65535; i++) begin
      step(1'b1, 6'((i % 63) + 1), 32'(i), 1'b0, 6'd0);
      s = sb.pop_front();
      if (wr_count !== s.cnt) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL preload_count bad_cycles=%0d want=0", bad); end
    checks++;
    if (wr_count !== 16'hFFFF) begin failures++; $display("FAIL preload_ffff got=%h want=ffff", wr_count); end
    step(1'b1, 6'd0, 32'h1, 1'b0, 6'd0);
    s = sb.pop_front();
    checks++;
    if (wr_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_addr0 got=%h want=ffff", wr_count); end
    step(1'b1, 6'd33, 32'hCAFE0001, 1'b0, 6'd0);
    s = sb.pop_front();
    checks++;
    if (wr_count !== 16'h0000) begin failures++; $display("FAIL wrap_count got=%h want=0000", wr_count); end
    checks++;
    if (q_all !== s.q) begin
      failures++; $display("FAIL wrap_q_all slice=%0d", first_diff(q_all, s.q));
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_zero();
    test_reserve();
    test_same_cycle();
    test_fill_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
